// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding, bit-timing helper and frame constants
// for the uart_word_tx block. Optional macro: UART_WORD_TX_PARITY_EN adds the
// PARITY state and lengthens each frame to 11 bit times.
package uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_WORD_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  localparam int FRAME_BITS = 10;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // Clock cycles per serial bit; integer truncation is intentional.
  function automatic int cycles_per_bit(input int clk_freq, input int bit_rate);
    return clk_freq / bit_rate;
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: word-write handshake plus status and serial line.
// Ports: write/write_data in, write_response/full/busy/tx out (slave view).
// master = word producer, slave = uart_word_tx.
interface uart_word_tx_if;
  logic        write;
  logic [31:0] write_data;
  logic        write_response;
  logic        full;
  logic        busy;
  logic        tx;

  modport master (output write, output write_data,
                  input write_response, input full, input busy, input tx);
  modport slave  (input write, input write_data,
                  output write_response, output full, output busy, output tx);
endinterface

// File: rtl/word_fifo.sv
// word_fifo: circular word FIFO, pointers wrap modulo DEPTH (power of two).
// Ports: clk, reset (sync active-low), push/din, pop/dout (show-ahead), full, empty.
// Push while full and pop while empty are ignored.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: buffers 32-bit words and sends each as WORD_SIZE_BY 8N1 frames, LSB byte first.
// Ports: clk, reset (sync active-low), bus (uart_word_tx_if.slave: write, write_data,
// write_response, full, busy, tx). Optional macro: UART_WORD_TX_PARITY_EN (even parity bit).
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int WORD_SIZE_BY = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  uart_word_tx_if.slave bus
);

  localparam int CPB = cycles_per_bit(CLK_FREQ, BIT_RATE);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int WW  = WORD_SIZE_BY * 8;
  localparam int BW  = (WORD_SIZE_BY > 1) ? $clog2(WORD_SIZE_BY) : 1;
  localparam logic [CW-1:0] LAST_CYC  = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_SIZE_BY - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [2:0]     bit_q, bit_d;
  logic [BW-1:0]  byte_q, byte_d;
  logic [WW-1:0]  word_q, word_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           resp_q;

  logic           push;
  logic           pop;
  logic           bit_done;
  logic           fifo_full;
  logic           fifo_empty;
  logic [31:0]    fifo_dout;

  // A write seen while full is dropped, even if a pop frees a slot this cycle.
  assign push = bus.write && !fifo_full;

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.write_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_done = (cyc_q == LAST_CYC);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    if (state_q != IDLE) cyc_d = bit_done ? '0 : cyc_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_d  = WW'(fifo_dout);  // zero-extends bytes beyond bit 31
          byte_d  = '0;
          cyc_d   = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = word_q[bit_q];
        if (bit_done) begin
          if (bit_q == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: begin
        tx_d = ^word_q[7:0];
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (byte_q != LAST_BYTE) begin
            byte_d  = byte_q + 1'b1;
            word_d  = word_q >> 8;  // current byte always sits in word_q[7:0]
            state_d = START;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            word_d  = WW'(fifo_dout);
            byte_d  = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_q != IDLE) || !fifo_empty;
  end

  // tx and busy are registered from the current state, so the line trails the
  // FSM by one cycle: a write at edge N enters START at N+1 and drives tx low at N+2.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      resp_q  <= push;
    end
  end

  assign bus.write_response = resp_q;
  assign bus.full           = fifo_full;
  assign bus.busy           = busy_q;
  assign bus.tx             = tx_q;

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 25000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BIT_RATE, default 9600, serial bit rate in bit/s.
REQ-003 The block SHALL have parameter WORD_SIZE_BY, default 4, bytes per transmitted word.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, word FIFO depth, power of two, 2 or greater.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-007 The block SHALL have port write, input, 1 bit, word write request.
REQ-008 The block SHALL have port write_data, input, 32 bits, word to transmit.
REQ-009 The block SHALL have port write_response, output, 1 bit, one-cycle acknowledge of an accepted write.
REQ-010 The block SHALL have port full, output, 1 bit, asserted when the FIFO holds FIFO_DEPTH words.
REQ-011 The block SHALL have port busy, output, 1 bit, asserted when a frame is in progress or the FIFO is non-empty.
REQ-012 The block SHALL have port tx, output, 1 bit, serial line, idle high.

Function
REQ-013 CYCLES_PER_BIT SHALL be CLK_FREQ/BIT_RATE, using integer truncation; every bit SHALL last exactly CYCLES_PER_BIT clk cycles.
REQ-014 A write SHALL be accepted when write=1 and full=0 at a clk edge, and write_response SHALL be 1 in the following cycle only.
REQ-015 A write with full=1 SHALL be discarded with no write_response, even if a word is popped in the same cycle.
REQ-016 Each word SHALL be sent as WORD_SIZE_BY frames, least-significant byte first; bytes above bit 31 SHALL be sent as zero.
REQ-017 Each frame SHALL be 8N1: one start bit 0, then data bits LSB first, then one stop bit 1.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, STOP, plus PARITY when the parity option is enabled.
- IDLE to START: when the FIFO is non-empty; pop one word.
- START to DATA: after one bit time.
- DATA to STOP: after 8 bit times.
- STOP to START: when bytes remain in the word, or when the word is done and the FIFO is non-empty.
- STOP to IDLE: otherwise.
REQ-019 Frames SHALL be back-to-back: the next start bit SHALL follow the last stop-bit cycle immediately, with no idle gap.
REQ-020 For a write accepted at edge N into an empty, idle block, tx SHALL go low from edge N+2.
REQ-021 FIFO order SHALL be strict first-in first-out; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 A simultaneous write and pop SHALL leave the occupancy count unchanged.
REQ-023 busy SHALL fall in the cycle after the final stop bit when the FIFO is empty.

Reset
REQ-024 With reset=0 at a clk edge, the block SHALL set tx=1, write_response=0, full=0, busy=0 and FSM=IDLE, empty the FIFO, and clear all counters.
REQ-025 A reset mid-frame SHALL abort the frame, return tx high at the next edge, and discard all pending words.

Configuration
REQ-026 With UART_WORD_TX_PARITY_EN defined, the block SHALL insert an even-parity bit, equal to the XOR of the 8 data bits, between DATA and STOP, using state PARITY; each frame is then 11 bit times.
REQ-027 Without UART_WORD_TX_PARITY_EN, the block SHALL contain no PARITY state or logic, and each frame SHALL be 10 bit times.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state encoding, the CYCLES_PER_BIT computation function, and the frame bit-count constants.
REQ-029 The FIFO SHALL be a separate sub-module word_fifo (ports: push, pop, data in, data out, full, empty); the bit timer and FSM SHALL stay in uart_word_tx.

Verification
All scenarios use CLK_FREQ=1000 and BIT_RATE=100, giving 10 cycles per bit.
REQ-030 Write 0x000000A5 while idle -> tx low at N+2 for 10 cycles, then bits 1,0,1,0,0,1,0,1, then stop 1, then three frames of byte 0x00; busy falls 400 cycles after the start bit begins.
REQ-031 Write 0x44332211 -> bytes on the line in order 0x11, 0x22, 0x33, 0x44, with no idle cycles between frames.
REQ-032 Five consecutive writes with FIFO_DEPTH=4 while transmitting -> full asserts, the fifth write gets no write_response, and only the four accepted words appear on tx in order.
REQ-033 Assert reset=0 for one cycle during DATA of byte 2 -> tx=1 next cycle, busy=0 and full=0; a subsequent write of 0x000000FF transmits normally.
REQ-034 With UART_WORD_TX_PARITY_EN, write 0x00000007 -> first frame has parity bit 1, the next three frames have parity bit 0, and each frame is 110 cycles.
